rv32i_instr_encoder: RTL and testbench
======================================

// Module: rv32i_instr_encoder
// PURPOSE
//  Inverse of the decode-stage control unit. Accepts field-level instruction commands
//  (op class, registers, funct3, immediate) from the loader/debug port and packs them
//  into legal RV32I instruction words. Words are buffered in a FIFO and drained over a
//  valid/ready stream into instruction memory or the fetch path.
//  Covers lw, sw, R-type, branch, I-type ALU, jal, lui and auipc.
// PARAMETERS
//  DEPTH  4  FIFO entries; power of 2, >=2
//  ERR_W  8  width of saturating error counter
// PORTS
//  clk          in   1             rising-edge clock
//  rst_n        in   1             asynchronous active-low reset
//  flush        in   1             synchronous FIFO clear
//  cmd_valid    in   1             command present
//  cmd_ready    out  1             command accepted when cmd_valid&&cmd_ready
//  cmd_op       in   3             0 LOAD,1 STORE,2 RTYPE,3 BRANCH,4 ITYPE,5 JAL,6 LUI,7 AUIPC
//  cmd_rd       in   5             destination register
//  cmd_rs1      in   5             source register 1
//  cmd_rs2      in   5             source register 2
//  cmd_funct3   in   3             funct3 (RTYPE/BRANCH/ITYPE only)
//  cmd_alt      in   1             funct7[5] (sub/sra/srai)
//  cmd_imm      in   32            signed byte immediate (LUI/AUIPC: value of imm[31:12])
//  instr_valid  out  1             FIFO head valid
//  instr_ready  in   1             consumer takes head when instr_valid&&instr_ready
//  instr_data   out  32            encoded instruction at FIFO head
//  fifo_count   out  clog2(DEPTH)+1  occupied entries
//  enc_err      out  1             one-cycle pulse: accepted command was illegal
//  err_count    out  ERR_W         saturating count of illegal commands
// BEHAVIOUR
//  Reset: FIFO empty; instr_valid=0, instr_data=0, fifo_count=0, enc_err=0, err_count=0,
//   cmd_ready=1.
//  Encoding is combinational from cmd_*; the word is written on the accept edge.
//   LOAD  op 0000011, f3 010, imm[11:0]->[31:20].
//   STORE op 0100011, f3 010, imm[11:5]->[31:25], imm[4:0]->[11:7].
//   RTYPE op 0110011, funct7={1'b0,cmd_alt,5'b0}.
//   BRANCH op 1100011, imm[12|10:5]->[31:25], imm[4:1|11]->[11:7].
//   ITYPE op 0010011; f3 001/101: [31:25]={1'b0,cmd_alt,5'b0}, [24:20]=imm[4:0].
//   JAL   op 1101111, imm[20|10:1|11|19:12]->[31:12].
//   LUI   op 0110111, AUIPC op 0010111; [31:12]=imm[31:12], imm[11:0] ignored.
//  Illegal commands (accepted, not written; enc_err=1 next cycle; err_count+1, saturate):
//   LOAD/STORE/ITYPE imm outside signed 12 bit; ITYPE shift with imm[11:5]!=0;
//   BRANCH imm outside signed 13 bit, imm[0]=1, or funct3 010/011;
//   JAL imm outside signed 21 bit or imm[0]=1; RTYPE cmd_alt=1 with f3 not 000/101.
//  Handshake: cmd_ready = !full (no same-cycle bypass when full). instr_valid = !empty.
//   instr_data = head entry, registered. Push-to-visible latency is 1 cycle.
//   instr_data and instr_valid hold while instr_valid && !instr_ready.
//  Simultaneous push+pop when not full and not empty: count unchanged; order preserved.
//  Pointers wrap modulo DEPTH; count is a separate (clog2+1)-bit field, so full is distinct.
//  flush: count:=0 and pointers:=0 next edge. A command accepted in the same cycle is
//   discarded and not counted as an error. err_count is not cleared by flush.
//  rst_n low mid-stream: all state clears immediately (async); in-flight words are lost.
// TESTING
//  LOAD rd=5 rs1=2 imm=-4 -> instr_data=0xFFC12283 one cycle after accept.
//  RTYPE rd=3 rs1=1 rs2=2 f3=0 alt=1 -> 0x402081B3.
//  BRANCH rs1=1 rs2=2 f3=0 imm=8 -> 0x00208463; JAL rd=1 imm=8 -> 0x008000EF.
//  BRANCH imm=3 -> no push, fifo_count unchanged, enc_err pulse, err_count=1.
//  instr_ready=0, push 4 words -> cmd_ready=0, count=4; then ready=1 -> drained in order.
//  flush + push same cycle -> count=0, no word out; rst_n low with 2 queued -> all outputs 0.

Source files
------------

// File: rtl/rv32i_instr_encoder.sv
// rtl/rv32i_instr_encoder.sv - packs field-level commands into RV32I words and queues them
// Illegal commands are consumed but never queued; they pulse encErr and bump a saturating counter.
module rv32i_instr_encoder #(
  parameter int DEPTH = 4,
  parameter int ERR_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [2:0]               cmd_op,
  input  logic [4:0]               cmd_rd,
  input  logic [4:0]               cmd_rs1,
  input  logic [4:0]               cmd_rs2,
  input  logic [2:0]               cmd_funct3,
  input  logic                     cmd_alt,
  input  logic [31:0]              cmd_imm,
  output logic                     instr_valid,
  input  logic                     instr_ready,
  output logic [31:0]              instr_data,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     enc_err,
  output logic [ERR_W-1:0]         err_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  localparam logic [2:0] OP_LOAD   = 3'd0;
  localparam logic [2:0] OP_STORE  = 3'd1;
  localparam logic [2:0] OP_RTYPE  = 3'd2;
  localparam logic [2:0] OP_BRANCH = 3'd3;
  localparam logic [2:0] OP_ITYPE  = 3'd4;
  localparam logic [2:0] OP_JAL    = 3'd5;
  localparam logic [2:0] OP_LUI    = 3'd6;

  logic [31:0] encWord;
  logic        encIllegal;
  logic        fits12, fits13, fits21, isShift;

  // A value fits N signed bits when everything from bit N-1 upward is a pure sign extension.
  assign fits12  = (&cmd_imm[31:11]) | ~(|cmd_imm[31:11]);
  assign fits13  = (&cmd_imm[31:12]) | ~(|cmd_imm[31:12]);
  assign fits21  = (&cmd_imm[31:20]) | ~(|cmd_imm[31:20]);
  assign isShift = (cmd_funct3 == 3'b001) || (cmd_funct3 == 3'b101);

  always_comb begin
    encWord    = '0;
    encIllegal = 1'b0;
    case (cmd_op)
      OP_LOAD: begin
        encWord    = {cmd_imm[11:0], cmd_rs1, 3'b010, cmd_rd, 7'b0000011};
        encIllegal = !fits12;
      end
      OP_STORE: begin
        encWord    = {cmd_imm[11:5], cmd_rs2, cmd_rs1, 3'b010, cmd_imm[4:0], 7'b0100011};
        encIllegal = !fits12;
      end
      OP_RTYPE: begin
        encWord    = {1'b0, cmd_alt, 5'b0, cmd_rs2, cmd_rs1, cmd_funct3, cmd_rd, 7'b0110011};
        encIllegal = cmd_alt && (cmd_funct3 != 3'b000) && (cmd_funct3 != 3'b101);
      end
      OP_BRANCH: begin
        encWord    = {cmd_imm[12], cmd_imm[10:5], cmd_rs2, cmd_rs1, cmd_funct3,
                      cmd_imm[4:1], cmd_imm[11], 7'b1100011};
        encIllegal = !fits13 || cmd_imm[0] || (cmd_funct3[2:1] == 2'b01);
      end
      OP_ITYPE: begin
        if (isShift) begin
          encWord    = {1'b0, cmd_alt, 5'b0, cmd_imm[4:0], cmd_rs1, cmd_funct3, cmd_rd, 7'b0010011};
          encIllegal = !fits12 || (|cmd_imm[11:5]);
        end else begin
          encWord    = {cmd_imm[11:0], cmd_rs1, cmd_funct3, cmd_rd, 7'b0010011};
          encIllegal = !fits12;
        end
      end
      OP_JAL: begin
        encWord    = {cmd_imm[20], cmd_imm[10:1], cmd_imm[11], cmd_imm[19:12], cmd_rd, 7'b1101111};
        encIllegal = !fits21 || cmd_imm[0];
      end
      OP_LUI:  encWord = {cmd_imm[31:12], cmd_rd, 7'b0110111};
      default: encWord = {cmd_imm[31:12], cmd_rd, 7'b0010111};
    endcase
  end

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wrPtr, rdPtr;
  logic [AW:0]   count;
  logic          full, empty, accept, push, pop, errHit;

  assign full   = (count == FULL_COUNT);
  assign empty  = (count == '0);
  assign accept = cmd_valid && !full;
  assign push   = accept && !encIllegal && !flush;
  assign pop    = !empty && instr_ready && !flush;
  assign errHit = accept && encIllegal && !flush;

  assign cmd_ready   = !full;
  assign instr_valid = !empty;
  assign instr_data  = empty ? 32'd0 : mem[rdPtr];
  assign fifo_count  = count;

  always_ff @(posedge clk) begin
    if (push) mem[wrPtr] <= encWord;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      count     <= '0;
      enc_err   <= 1'b0;
      err_count <= '0;
    end else begin
      enc_err <= errHit;
      if (errHit && (err_count != {ERR_W{1'b1}})) err_count <= err_count + 1'b1;
      if (flush) begin
        wrPtr <= '0;
        rdPtr <= '0;
        count <= '0;
      end else begin
        if (push) wrPtr <= wrPtr + 1'b1;
        if (pop)  rdPtr <= rdPtr + 1'b1;
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rv32i_instr_encoder.sv
// tb/tb_rv32i_instr_encoder.sv - randomized bench with a field-arithmetic reference encoder and queue model
module tb_rv32i_instr_encoder;

  localparam int DEPTH = 4;
  localparam int ERR_MAX = 255;

  logic        clk = 1'b0;
  logic        rst_n, flush, cmdValid, cmdAlt, instrReady;
  logic [2:0]  cmdOp, cmdFunct3;
  logic [4:0]  cmdRd, cmdRs1, cmdRs2;
  logic [31:0] cmdImm;
  logic        cmd_ready, instr_valid, enc_err;
  logic [31:0] instr_data;
  logic [2:0]  fifo_count;
  logic [7:0]  err_count;

  int checks = 0;
  int errors = 0;
  logic [31:0] expQ[$];
  int  expErrCnt = 0;
  bit  expEncErr = 0;
  int  bnd[12] = '{-2048, 2047, 2048, -2049, -4096, 4094, 4096, -4098,
                   1048574, -1048576, 1048576, -1048578};

  rv32i_instr_encoder #(.DEPTH(DEPTH), .ERR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .cmd_valid(cmdValid), .cmd_ready(cmd_ready),
    .cmd_op(cmdOp), .cmd_rd(cmdRd), .cmd_rs1(cmdRs1), .cmd_rs2(cmdRs2),
    .cmd_funct3(cmdFunct3), .cmd_alt(cmdAlt), .cmd_imm(cmdImm),
    .instr_valid(instr_valid), .instr_ready(instrReady), .instr_data(instr_data),
    .fifo_count(fifo_count), .enc_err(enc_err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  // Reference encoder: builds each word from field values with shifts and masks.
  function automatic void modelEnc(input int op, input int rd, input int rs1, input int rs2,
                                   input int f3, input int alt, input int s,
                                   output logic [31:0] w, output bit ill);
    bit shamt;
    ill = 0;
    w   = 0;
    case (op)
      0: begin
        ill = (s < -2048) || (s > 2047);
        w = 32'(((s & 'hFFF) << 20) | (rs1 << 15) | (2 << 12) | (rd << 7) | 'h03);
      end
      1: begin
        ill = (s < -2048) || (s > 2047);
        w = 32'((((s >>> 5) & 'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (2 << 12)
                | ((s & 'h1F) << 7) | 'h23);
      end
      2: begin
        ill = (alt != 0) && (f3 != 0) && (f3 != 5);
        w = 32'((alt << 30) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 'h33);
      end
      3: begin
        ill = (s < -4096) || (s > 4095) || ((s & 1) != 0) || (f3 == 2) || (f3 == 3);
        w = 32'((((s >>> 12) & 1) << 31) | (((s >>> 5) & 'h3F) << 25) | (rs2 << 20)
                | (rs1 << 15) | (f3 << 12) | (((s >>> 1) & 'hF) << 8)
                | (((s >>> 11) & 1) << 7) | 'h63);
      end
      4: begin
        shamt = (f3 == 1) || (f3 == 5);
        ill = (s < -2048) || (s > 2047) || (shamt && (((s >>> 5) & 'h7F) != 0));
        if (shamt)
          w = 32'((alt << 30) | ((s & 'h1F) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 'h13);
        else
          w = 32'(((s & 'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 'h13);
      end
      5: begin
        ill = (s < -(1 << 20)) || (s > (1 << 20) - 1) || ((s & 1) != 0);
        w = 32'((((s >>> 20) & 1) << 31) | (((s >>> 1) & 'h3FF) << 21)
                | (((s >>> 11) & 1) << 20) | (((s >>> 12) & 'hFF) << 12) | (rd << 7) | 'h6F);
      end
      6: w = 32'((s & 32'hFFFFF000) | (rd << 7) | 'h37);
      default: w = 32'((s & 32'hFFFFF000) | (rd << 7) | 'h17);
    endcase
  endfunction

  task automatic setCmd(input int op, input int rd, input int rs1, input int rs2,
                        input int f3, input int alt, input int imm);
    cmdValid = 1'b1;
    cmdOp = 3'(op); cmdRd = 5'(rd); cmdRs1 = 5'(rs1); cmdRs2 = 5'(rs2);
    cmdFunct3 = 3'(f3); cmdAlt = 1'(alt); cmdImm = 32'(imm);
  endtask

  task automatic randCmd(input bit legalOnly);
    logic [31:0] w;
    bit ill;
    int s;
    do begin
      case ($urandom_range(0, 5))
        0: s = int'($urandom_range(0, 127)) - 64;
        1: s = int'($urandom_range(0, 4095)) - 2048;
        2: s = bnd[$urandom_range(0, 11)];
        3: s = int'($urandom_range(0, 2097151)) - 1048576;
        4: s = int'($urandom);
        default: s = (int'($urandom_range(0, 8191)) - 4096) & ~1;
      endcase
      setCmd($urandom_range(0, 7), $urandom_range(0, 31), $urandom_range(0, 31),
             $urandom_range(0, 31), $urandom_range(0, 7), $urandom_range(0, 1), s);
      modelEnc(cmdOp, cmdRd, cmdRs1, cmdRs2, cmdFunct3, cmdAlt, $signed(cmdImm), w, ill);
    end while (legalOnly && ill);
  endtask

  // Advances one clock and updates the model from the inputs present at the edge.
  task automatic tick();
    logic [31:0] w;
    bit ill, acc, popOk;
    modelEnc(cmdOp, cmdRd, cmdRs1, cmdRs2, cmdFunct3, cmdAlt, $signed(cmdImm), w, ill);
    acc   = cmdValid && (expQ.size() < DEPTH);
    popOk = (expQ.size() > 0) && instrReady;
    @(posedge clk);
    #1;
    expEncErr = 0;
    if (flush) begin
      expQ.delete();
    end else begin
      if (popOk) void'(expQ.pop_front());
      if (acc && !ill) expQ.push_back(w);
      if (acc && ill) begin
        expEncErr = 1;
        if (expErrCnt < ERR_MAX) expErrCnt++;
      end
    end
  endtask

  task automatic test_reset();
    checks += 6;
    if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", instr_valid); end
    if (instr_data !== 32'd0) begin errors++; $display("FAIL reset_data: got %h expected 0", instr_data); end
    if (fifo_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", fifo_count); end
    if (enc_err !== 1'b0) begin errors++; $display("FAIL reset_enc_err: got %b expected 0", enc_err); end
    if (err_count !== 8'd0) begin errors++; $display("FAIL reset_err_count: got %0d expected 0", err_count); end
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %b expected 1", cmd_ready); end
  endtask

  task automatic test_directed();
    int vec[4][7] = '{'{0, 5, 2, 0, 0, 0, -4}, '{2, 3, 1, 2, 0, 1, 0},
                      '{3, 0, 1, 2, 0, 0, 8}, '{5, 1, 0, 0, 0, 0, 8}};
    logic [31:0] golden[4] = '{32'hFFC12283, 32'h402081B3, 32'h00208463, 32'h008000EF};
    instrReady = 1'b0;
    for (int i = 0; i < 4; i++) begin
      setCmd(vec[i][0], vec[i][1], vec[i][2], vec[i][3], vec[i][4], vec[i][5], vec[i][6]);
      tick();
      cmdValid = 1'b0;
      checks += 3;
      if (instr_data !== golden[i]) begin errors++; $display("FAIL directed_word%0d: got %h expected %h", i, instr_data, golden[i]); end
      if (expQ.size() != 1 || instr_data !== expQ[0]) begin errors++; $display("FAIL directed_model%0d: got %h expected model head", i, instr_data); end
      if (instr_valid !== 1'b1) begin errors++; $display("FAIL directed_valid%0d: got %b expected 1", i, instr_valid); end
      instrReady = 1'b1;
      tick();
      instrReady = 1'b0;
      checks++;
      if (fifo_count !== 3'd0) begin errors++; $display("FAIL directed_drain%0d: got %0d expected 0", i, fifo_count); end
    end
  endtask

  task automatic test_illegal();
    setCmd(3, 0, 1, 2, 0, 0, 3);
    tick();
    cmdValid = 1'b0;
    checks += 3;
    if (fifo_count !== 3'd0) begin errors++; $display("FAIL illegal_count: got %0d expected 0", fifo_count); end
    if (enc_err !== 1'b1) begin errors++; $display("FAIL illegal_pulse: got %b expected 1", enc_err); end
    if (err_count !== 8'd1) begin errors++; $display("FAIL illegal_err_count: got %0d expected 1", err_count); end
    tick();
    checks++;
    if (enc_err !== 1'b0) begin errors++; $display("FAIL illegal_pulse_end: got %b expected 0", enc_err); end
  endtask

  task automatic test_full();
    logic [31:0] pushed[$];
    instrReady = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      randCmd(1'b1);
      tick();
      pushed.push_back(expQ[expQ.size() - 1]);
    end
    checks += 2;
    if (cmd_ready !== 1'b0) begin errors++; $display("FAIL full_cmd_ready: got %b expected 0", cmd_ready); end
    if (fifo_count !== 3'(DEPTH)) begin errors++; $display("FAIL full_count: got %0d expected %0d", fifo_count, DEPTH); end
    randCmd(1'b1);
    tick();
    cmdValid = 1'b0;
    checks++;
    if (fifo_count !== 3'(DEPTH)) begin errors++; $display("FAIL full_no_push: got %0d expected %0d", fifo_count, DEPTH); end
    instrReady = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (instr_data !== pushed[i]) begin errors++; $display("FAIL drain_order%0d: got %h expected %h", i, instr_data, pushed[i]); end
      tick();
    end
    instrReady = 1'b0;
    checks++;
    if (instr_valid !== 1'b0) begin errors++; $display("FAIL drain_empty: got %b expected 0", instr_valid); end
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 9) < 7) randCmd(1'b0); else cmdValid = 1'b0;
      instrReady = ($urandom_range(0, 9) < 6);
      flush = ($urandom_range(0, 39) == 0);
      tick();
      checks += 6;
      if (instr_valid !== (expQ.size() > 0)) begin errors++; $display("FAIL rand_valid@%0d: got %b expected %b", c, instr_valid, expQ.size() > 0); end
      if (expQ.size() > 0 && instr_data !== expQ[0]) begin errors++; $display("FAIL rand_data@%0d: got %h expected %h", c, instr_data, expQ[0]); end
      if (fifo_count !== 3'(expQ.size())) begin errors++; $display("FAIL rand_count@%0d: got %0d expected %0d", c, fifo_count, expQ.size()); end
      if (cmd_ready !== (expQ.size() < DEPTH)) begin errors++; $display("FAIL rand_cmd_ready@%0d: got %b expected %b", c, cmd_ready, expQ.size() < DEPTH); end
      if (enc_err !== expEncErr) begin errors++; $display("FAIL rand_enc_err@%0d: got %b expected %b", c, enc_err, expEncErr); end
      if (err_count !== 8'(expErrCnt)) begin errors++; $display("FAIL rand_err_count@%0d: got %0d expected %0d", c, err_count, expErrCnt); end
    end
    flush = 1'b0;
    cmdValid = 1'b0;
    instrReady = 1'b1;
    repeat (DEPTH) tick();
    instrReady = 1'b0;
  endtask

  task automatic test_flush();
    int errBefore;
    instrReady = 1'b0;
    repeat (2) begin randCmd(1'b1); tick(); end
    randCmd(1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    cmdValid = 1'b0;
    checks += 3;
    if (fifo_count !== 3'd0) begin errors++; $display("FAIL flush_count: got %0d expected 0", fifo_count); end
    if (instr_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b expected 0", instr_valid); end
    if (enc_err !== 1'b0) begin errors++; $display("FAIL flush_enc_err: got %b expected 0", enc_err); end
    errBefore = expErrCnt;
    setCmd(3, 0, 1, 2, 0, 0, 3);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    randCmd(1'b1);
    tick();
    cmdValid = 1'b0;
    checks += 3;
    if (err_count !== 8'(errBefore)) begin errors++; $display("FAIL flush_err_uncounted: got %0d expected %0d", err_count, errBefore); end
    if (fifo_count !== 3'd1) begin errors++; $display("FAIL flush_repush_count: got %0d expected 1", fifo_count); end
    if (instr_data !== expQ[0]) begin errors++; $display("FAIL flush_repush_data: got %h expected %h", instr_data, expQ[0]); end
    instrReady = 1'b1;
    tick();
    instrReady = 1'b0;
  endtask

  task automatic test_reset_mid();
    repeat (2) begin randCmd(1'b1); tick(); end
    setCmd(3, 0, 1, 2, 0, 0, 3);
    tick();
    cmdValid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    expQ.delete();
    expErrCnt = 0;
    expEncErr = 0;
    checks += 6;
    if (instr_valid !== 1'b0) begin errors++; $display("FAIL arst_valid: got %b expected 0", instr_valid); end
    if (instr_data !== 32'd0) begin errors++; $display("FAIL arst_data: got %h expected 0", instr_data); end
    if (fifo_count !== 3'd0) begin errors++; $display("FAIL arst_count: got %0d expected 0", fifo_count); end
    if (enc_err !== 1'b0) begin errors++; $display("FAIL arst_enc_err: got %b expected 0", enc_err); end
    if (err_count !== 8'd0) begin errors++; $display("FAIL arst_err_count: got %0d expected 0", err_count); end
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL arst_cmd_ready: got %b expected 1", cmd_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_saturate();
    setCmd(5, 1, 0, 0, 0, 0, 7);
    for (int i = 0; i < 270; i++) tick();
    cmdValid = 1'b0;
    checks += 2;
    if (err_count !== 8'hFF) begin errors++; $display("FAIL sat_err_count: got %0d expected 255", err_count); end
    if (err_count !== 8'(expErrCnt)) begin errors++; $display("FAIL sat_model: got %0d expected %0d", err_count, expErrCnt); end
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; cmdValid = 1'b0; instrReady = 1'b0;
    cmdOp = '0; cmdRd = '0; cmdRs1 = '0; cmdRs2 = '0; cmdFunct3 = '0; cmdAlt = 1'b0; cmdImm = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    test_reset();
    test_directed();
    test_illegal();
    test_full();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
